alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU (ops ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111) between two requesters, e.g. the main pipeline EX stage and a branch/address helper.
- Arbitrates round-robin and registers the winner's operands onto the ALU input ports.
- Captures ALUResult/Zero one cycle later and returns them to the winner over a valid/ready response channel.
- Only one operation is in flight at a time.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 4, ALUControl width.

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Req0Valid  in  1  requester 0 has an op
- Req0Ready  out  1  requester 0 op accepted this cycle
- Req0Op  in  OP_W  requester 0 ALUControl code
- Req0A, Req0B  in  DATA_W  requester 0 operands
- Resp0Valid  out  1  requester 0 result valid
- Resp0Ready  in  1  requester 0 takes result
- Resp0Result  out  DATA_W  result
- Resp0Zero  out  1  zero flag
- Resp0Err  out  1  illegal-op flag (see Optional Feature)
- Req1*/Resp1*  same set for requester 1
- AluControl  out  OP_W  to ALU ALUControl
- AluA, AluB  out  DATA_W  to ALU A/B
- AluResult  in  DATA_W  from ALU
- AluZero  in  1  from ALU Zero

Behaviour:
- Clock and reset: one clock Clk; reset Rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, rr pointer=0 (requester 0 preferred).
  - AluControl=0010, AluA=0, AluB=0.
  - All Ready/Valid=0; Result=0, Zero=0, Err=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is combinational from Req*Valid and the pointer.
  - Only one valid: that requester wins.
  - Both valid: the pointer's requester wins.
  - ReqNReady=1 only for the winner, only in IDLE.
  - On handshake (valid&ready), register Op/A/B onto AluControl/AluA/AluB, record owner, flip pointer to the non-owner, go to EXEC.
  - No valid: stay in IDLE; ALU outputs hold their last values.
- EXEC: ALU evaluates combinationally. At the clock edge, capture AluResult/AluZero into the owner's Result/Zero registers, go to RESP.
- RESP:
  - Owner's RespNValid=1 and the response is held stable until RespNReady=1.
  - On the Valid&Ready edge, RespNValid->0 and state->IDLE.
  - A new accept can occur in IDLE the next cycle, so sustained throughput is 1 op per 3 cycles.
- Latency: accept edge at cycle t -> RespNValid high from cycle t+2. With Ready already high, the response is consumed at t+2 and the next accept happens at t+3.
- The non-owner's Resp outputs keep their previous Result/Zero; its Valid stays 0.
- No Ready is asserted outside IDLE. Requests stay pending; requesters must hold Op/A/B stable while Valid=1 and not accepted.
- Pointer changes only on an accepted grant, so a lone requester is never blocked by an idle partner.
- Operands are captured at accept. Input changes after accept do not affect the in-flight op.
- Result width: full DATA_W, no extension. SLT result is 32'h1 or 0, exactly as the ALU delivers.
- Unknown op codes (without OPCHECK) pass through. The ALU then holds its previous result, so the captured value equals the last ALU output.
- Rst_n low in any state immediately clears to reset values and drops the in-flight op; no response is issued for it.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - In IDLE, an accepted op not in {0000,0001,0010,0110,0111} skips EXEC and goes to RESP directly (latency 1).
  - Response carries Result=0, Zero=0, Err=1.
  - AluControl/AluA/AluB are not updated.
  - Legal ops return Err=0.
- Not defined: Resp0Err/Resp1Err are tied 0 and all codes issue normally.

Test Plan:
- Req0 ADD A=5 B=7, Resp0Ready=1 -> Req0Ready pulse in IDLE; Resp0Valid 2 cycles later, Result=12, Zero=0; AluControl=0010.
- Both valid after reset: Req0 SUB 9-9, Req1 OR F0|0F -> req0 served first (Result=0, Zero=1), then req1 accepted in the next IDLE (Result=0x000000FF).
- Req1 held continuously with Req0 idle -> req1 accepted every 3 cycles; pointer does not starve it.
- Resp0Ready=0 for 5 cycles on SLT A=1 B=2 -> Resp0Valid and Result=1 held stable; Req1Ready stays 0 throughout; release -> IDLE next cycle.
- Rst_n asserted asynchronously during EXEC -> all outputs reset immediately; no Resp valid after release; next request served with pointer=0.
- With ALU_ARB_OPCHECK_EN, Req0Op=1111 -> Resp0Valid 1 cycle after accept, Err=1, Result=0; AluA unchanged. Without the macro -> normal 2-cycle issue, Err=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters, one op in flight.
// Optional ALU_ARB_OPCHECK_EN: reject unknown op codes with an error response instead of issuing them.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  // requester 0
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [OP_W-1:0]   Req0Op,
  input  logic [DATA_W-1:0] Req0A,
  input  logic [DATA_W-1:0] Req0B,
  output logic              Resp0Valid,
  input  logic              Resp0Ready,
  output logic [DATA_W-1:0] Resp0Result,
  output logic              Resp0Zero,
  output logic              Resp0Err,
  // requester 1
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [OP_W-1:0]   Req1Op,
  input  logic [DATA_W-1:0] Req1A,
  input  logic [DATA_W-1:0] Req1B,
  output logic              Resp1Valid,
  input  logic              Resp1Ready,
  output logic [DATA_W-1:0] Resp1Result,
  output logic              Resp1Zero,
  output logic              Resp1Err,
  // shared ALU
  output logic [OP_W-1:0]   AluControl,
  output logic [DATA_W-1:0] AluA,
  output logic [DATA_W-1:0] AluB,
  input  logic [DATA_W-1:0] AluResult,
  input  logic              AluZero
);

  localparam logic [OP_W-1:0] OP_AND = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(4'b0111);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              rr_q;        // preferred requester when both are valid
  logic              owner_q;     // requester whose op is in flight
  logic              grant0, grant1;
  logic              accept, win, op_bad, resp_fire;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [1:0]        valid_q;
  logic [1:0]        zero_q;
  logic [DATA_W-1:0] result_q [2];

  // Grant is purely combinational; the pointer only breaks ties.
  assign grant0 = Req0Valid & (~Req1Valid | ~rr_q);
  assign grant1 = Req1Valid & (~Req0Valid |  rr_q);

  assign Req0Ready = (state_q == S_IDLE) & grant0;
  assign Req1Ready = (state_q == S_IDLE) & grant1;

  assign accept = (Req0Valid & Req0Ready) | (Req1Valid & Req1Ready);
  assign win    = Req1Ready;

  assign sel_op = win ? Req1Op : Req0Op;
  assign sel_a  = win ? Req1A  : Req0A;
  assign sel_b  = win ? Req1B  : Req0B;

`ifdef ALU_ARB_OPCHECK_EN
  assign op_bad = !(sel_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT});
`else
  assign op_bad = 1'b0;
`endif

  assign resp_fire = valid_q[owner_q] & (owner_q ? Resp1Ready : Resp0Ready);

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = op_bad ? S_RESP : S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: if (resp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      AluControl <= OP_ADD;
      AluA       <= '0;
      AluB       <= '0;
    end else if (state_q == S_IDLE && accept) begin
      owner_q <= win;
      rr_q    <= ~win;
      // A rejected op leaves the ALU inputs untouched.
      if (!op_bad) begin
        AluControl <= sel_op;
        AluA       <= sel_a;
        AluB       <= sel_b;
      end
    end
  end

  // NOTE: the two-entry result array is reset like any other register because its contents are visible on the ports.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q     <= '0;
      zero_q      <= '0;
      result_q[0] <= '0;
      result_q[1] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && op_bad) begin
            valid_q[win]  <= 1'b1;
            zero_q[win]   <= 1'b0;
            result_q[win] <= '0;
          end
        end
        S_EXEC: begin
          valid_q[owner_q]  <= 1'b1;
          zero_q[owner_q]   <= AluZero;
          result_q[owner_q] <= AluResult;
        end
        S_RESP: begin
          if (resp_fire) valid_q[owner_q] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic [1:0] err_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err_q <= '0;
    end else if (state_q == S_IDLE && accept && op_bad) begin
      err_q[win] <= 1'b1;
    end else if (state_q == S_EXEC) begin
      err_q[owner_q] <= 1'b0;
    end
  end

  assign Resp0Err = err_q[0];
  assign Resp1Err = err_q[1];
`else
  assign Resp0Err = 1'b0;
  assign Resp1Err = 1'b0;
`endif

  assign Resp0Valid  = valid_q[0];
  assign Resp0Zero   = zero_q[0];
  assign Resp0Result = result_q[0];
  assign Resp1Valid  = valid_q[1];
  assign Resp1Zero   = zero_q[1];
  assign Resp1Result = result_q[1];

  // Structural invariants of a single-issue arbiter.
  a_one_ready : assert property (@(posedge Clk) disable iff (!Rst_n) !(Req0Ready && Req1Ready));
  a_one_resp  : assert property (@(posedge Clk) disable iff (!Rst_n) !(Resp0Valid && Resp1Valid));

endmodule
